nrisc_wishbone_master: RTL
==========================

Name: nrisc_wishbone_master

Overview:
Wishbone classic-cycle initiator for the NRISC-Aurora core. It is the counterpart of the existing Wishbone slave.
- Takes single-word load/store requests from the CPU memory stage.
- Drives CYC/STB/WE/ADR/DAT/SEL/tags on the bus.
- Completes on ACK, ERR, RTY or timeout, with bounded automatic retry.
- Returns read data and a status code to the CPU.

Parameters:
TAM, 16, data/address width in bits (matches `TAM in const.v).
SEL_W, TAM/8, byte-select width.
MAX_RETRY, 3, RTY responses tolerated before failing (0 = no retry).
RETRY_GAP, 2, idle cycles with CYC low between RTY and reissue (>=1).
TIMEOUT, 255, cycles in a bus cycle without response before abort (>=2).

Ports:
WSHMSTR_CLKIN  in  1  clock; all logic on the rising edge.
WSHMSTR_RSTIN  in  1  reset; synchronous, active-high.
CPU_REQ  in  1  request strobe; sampled only while CPU_BUSY=0.
CPU_WREN  in  1  1=write, 0=read.
CPU_ADDR  in  TAM  word address.
CPU_WDATA  in  TAM  write data.
CPU_SEL  in  SEL_W  byte lanes.
CPU_LOCK  in  1  request bus lock for this cycle.
CPU_TGA, CPU_TGC, CPU_TGD  in  8 each  address, cycle and data tags.
CPU_BUSY  out  1  transaction in flight.
CPU_DONE  out  1  one-cycle completion pulse.
CPU_ERRCODE  out  2  00 ok, 01 bus ERR, 10 retry exhausted, 11 timeout; valid with CPU_DONE.
CPU_RDATA  out  TAM  read data; valid with CPU_DONE on an ok read.
CPU_TGDIN  out  8  data tag captured with read data.
WSHMSTR_CYC  out  1  bus cycle.
WSHMSTR_STROBE  out  1  strobe.
WSHMSTR_WREN  out  1  write enable.
WSHMSTR_LOCKOUT  out  1  lock.
WSHMSTR_ADDROUT  out  TAM  address.
WSHMSTR_DATAOUT  out  TAM  write data.
WSHMSTR_SEL  out  SEL_W  byte select.
WSHMSTR_TGA, WSHMSTR_TGC, WSHMSTR_TGDOUT  out  8 each  tags.
WSHMSTR_DATAIN  in  TAM  read data.
WSHMSTR_TGDIN  in  8  read data tag.
WSHMSTR_ACK  in  1  acknowledge.
WSHMSTR_ERRIN  in  1  error.
WSHMSTR_RETRY  in  1  retry.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
  - Reset asserted mid-transaction drops CYC/STB at the next edge.
  - No CPU_DONE is issued for the aborted transaction.
- All bus outputs are registered, and so are CPU_DONE, CPU_ERRCODE and CPU_RDATA.
- States:
  - IDLE: BUSY=0. If CPU_REQ=1, latch all CPU_* request fields and go to CYCLE.
  - CYCLE: CYC=STB=1; outputs come from the latched fields. Responses are sampled each edge with priority ERRIN > RETRY > ACK; simultaneous responses are resolved by this priority.
    - ACK: DONE=1, ERRCODE=00; on a read, CPU_RDATA<=DATAIN and CPU_TGDIN<=TGDIN. Go to IDLE.
    - ERRIN: DONE=1, ERRCODE=01, go to IDLE.
    - RETRY with retry_cnt<MAX_RETRY: retry_cnt++, go to BACKOFF.
    - RETRY with retry_cnt==MAX_RETRY: DONE=1, ERRCODE=10, go to IDLE.
    - No response and wait_cnt==TIMEOUT-1: DONE=1, ERRCODE=11, go to IDLE.
  - BACKOFF: CYC=STB=0, BUSY=1. Stay RETRY_GAP cycles, then return to CYCLE with wait_cnt cleared and the same latched fields.
- Latency:
  - CPU_REQ high at edge n gives CYC/STB high from n+1.
  - Response sampled at edge m gives CPU_DONE high in cycle m+1, CYC/STB low in cycle m+1, and IDLE at m+1.
  - A back-to-back CPU_REQ is accepted at m+1, so the minimum transaction is 2 cycles and the peak rate is one transaction per 2 cycles.
- CPU_DONE lasts exactly one cycle. CPU_RDATA holds its value until the next ok read.
- On a write, or on any error, CPU_RDATA is unchanged.
- CPU_REQ while BUSY=1 is ignored (not queued).
- CPU request inputs may change after acceptance without effect.
- Responses while CYC=0 (IDLE/BACKOFF) are ignored.
- wait_cnt counts from 0 on CYCLE entry and saturates. retry_cnt clears on every IDLE→CYCLE transition.
- LOCKOUT equals latched lock while CYC=1, and is 0 otherwise (including BACKOFF).

Decomposition:
- const.v additions: WB master state encodings (IDLE, CYCLE, BACKOFF) and the ERRCODE constants (OK, BUSERR, RETRYMAX, TIMEOUT).
- One sub-module, nrisc_wb_watchdog: a loadable wait/backoff counter with terminal-count output. It is instanced once; the FSM reuses it for both the timeout and the backoff gap.

Test Plan:
1. Read: REQ addr=0x1234, WREN=0, SEL=2'b11; slave ACKs 3 cycles after STB with DATAIN=0xBEEF -> DONE one cycle, ERRCODE=00, RDATA=0xBEEF, STB high exactly 3 cycles.
2. Write: REQ addr=0x0010, WDATA=0xA5A5; slave ACKs on the first STB cycle -> bus shows WREN=1, DATAOUT=0xA5A5; DONE at 2nd cycle after REQ; new REQ accepted same cycle.
3. Retry: slave RTYs twice then ACKs -> two BACKOFF gaps of 2 cycles with CYC=0, same ADDROUT each issue, final ERRCODE=00; with 4 RTYs -> ERRCODE=10 after the 4th.
4. Silent slave, TIMEOUT=255 -> DONE with ERRCODE=11 exactly 255 cycles after STB rise; CYC low next cycle.
5. ERRIN and ACK asserted together -> ERRCODE=01, RDATA unchanged.
6. RSTIN asserted during CYCLE -> CYC/STB/BUSY=0 at next edge, no DONE; REQ after reset release proceeds normally.

Source files
------------

// File: rtl/nrisc_wishbone_master_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nrisc_wishbone_master_pkg
// Brief    : State encodings, completion codes and helpers for the WB master.
// Revision : 1.0 - initial release
// ============================================================================
package nrisc_wishbone_master_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CYCLE   = 2'd1,
        S_BACKOFF = 2'd2
    } wbm_state_t;

    localparam logic [1:0] c_err_ok       = 2'b00;
    localparam logic [1:0] c_err_buserr   = 2'b01;
    localparam logic [1:0] c_err_retrymax = 2'b10;
    localparam logic [1:0] c_err_timeout  = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nrisc_wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_wb_watchdog
// Brief    : Loadable down-counter that saturates at zero; o_tc flags zero.
// Revision : 1.0 - initial release
// ============================================================================
module nrisc_wb_watchdog #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/nrisc_wishbone_master.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_wishbone_master
// Brief    : Wishbone classic-cycle initiator with bounded retry and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module nrisc_wishbone_master
    import nrisc_wishbone_master_pkg::*;
#(
    parameter int TAM       = 16,
    parameter int SEL_W     = TAM / 8,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic             WSHMSTR_CLKIN,
    input  logic             WSHMSTR_RSTIN,
    input  logic             CPU_REQ,
    input  logic             CPU_WREN,
    input  logic [TAM-1:0]   CPU_ADDR,
    input  logic [TAM-1:0]   CPU_WDATA,
    input  logic [SEL_W-1:0] CPU_SEL,
    input  logic             CPU_LOCK,
    input  logic [7:0]       CPU_TGA,
    input  logic [7:0]       CPU_TGC,
    input  logic [7:0]       CPU_TGD,
    output logic             CPU_BUSY,
    output logic             CPU_DONE,
    output logic [1:0]       CPU_ERRCODE,
    output logic [TAM-1:0]   CPU_RDATA,
    output logic [7:0]       CPU_TGDIN,
    output logic             WSHMSTR_CYC,
    output logic             WSHMSTR_STROBE,
    output logic             WSHMSTR_WREN,
    output logic             WSHMSTR_LOCKOUT,
    output logic [TAM-1:0]   WSHMSTR_ADDROUT,
    output logic [TAM-1:0]   WSHMSTR_DATAOUT,
    output logic [SEL_W-1:0] WSHMSTR_SEL,
    output logic [7:0]       WSHMSTR_TGA,
    output logic [7:0]       WSHMSTR_TGC,
    output logic [7:0]       WSHMSTR_TGDOUT,
    input  logic [TAM-1:0]   WSHMSTR_DATAIN,
    input  logic [7:0]       WSHMSTR_TGDIN,
    input  logic             WSHMSTR_ACK,
    input  logic             WSHMSTR_ERRIN,
    input  logic             WSHMSTR_RETRY
);

    localparam int c_wd_w = $clog2(max_int(TIMEOUT, RETRY_GAP));
    localparam int c_rc_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_rc_w-1:0] c_max_retry  = c_rc_w'(MAX_RETRY);
    localparam logic [c_wd_w-1:0] c_timeout_ld = c_wd_w'(TIMEOUT - 1);
    localparam logic [c_wd_w-1:0] c_gap_ld     = c_wd_w'(RETRY_GAP - 1);

    wbm_state_t        r_state, w_next;
    logic              r_cyc, r_lockout, r_done;
    logic [1:0]        r_errcode;
    logic [TAM-1:0]    r_rdata;
    logic [7:0]        r_tgdin;
    logic [c_rc_w-1:0] r_retry_cnt;

    logic              r_wren, r_lock;
    logic [TAM-1:0]    r_addr, r_wdata;
    logic [SEL_W-1:0]  r_sel;
    logic [7:0]        r_tga, r_tgc, r_tgd;

    logic              w_accept, w_done, w_capture, w_retry_inc, w_lock_nxt;
    logic [1:0]        w_errcode;
    logic              w_wd_load, w_wd_tc;
    logic [c_wd_w-1:0] w_wd_val;

    assign w_accept   = (r_state == S_IDLE) && CPU_REQ;
    assign w_lock_nxt = w_accept ? CPU_LOCK : r_lock;

    // One counter serves both the response timeout and the backoff gap;
    // it is reloaded on every entry into CYCLE or BACKOFF.
    assign w_wd_load = (w_next != r_state) && (w_next != S_IDLE);
    assign w_wd_val  = (w_next == S_CYCLE) ? c_timeout_ld : c_gap_ld;

    nrisc_wb_watchdog #(
        .WIDTH (c_wd_w)
    ) u_watchdog (
        .clk        (WSHMSTR_CLKIN),
        .rst        (WSHMSTR_RSTIN),
        .i_load     (w_wd_load),
        .i_load_val (w_wd_val),
        .o_tc       (w_wd_tc)
    );

    always_comb begin
        w_next      = r_state;
        w_done      = 1'b0;
        w_errcode   = c_err_ok;
        w_capture   = 1'b0;
        w_retry_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (CPU_REQ) w_next = S_CYCLE;
            end
            S_CYCLE: begin
                if (WSHMSTR_ERRIN) begin
                    w_done    = 1'b1;
                    w_errcode = c_err_buserr;
                    w_next    = S_IDLE;
                end else if (WSHMSTR_RETRY) begin
                    if (r_retry_cnt < c_max_retry) begin
                        w_retry_inc = 1'b1;
                        w_next      = S_BACKOFF;
                    end else begin
                        w_done    = 1'b1;
                        w_errcode = c_err_retrymax;
                        w_next    = S_IDLE;
                    end
                end else if (WSHMSTR_ACK) begin
                    w_done    = 1'b1;
                    w_capture = ~r_wren;
                    w_next    = S_IDLE;
                end else if (w_wd_tc) begin
                    w_done    = 1'b1;
                    w_errcode = c_err_timeout;
                    w_next    = S_IDLE;
                end
            end
            S_BACKOFF: begin
                if (w_wd_tc) w_next = S_CYCLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge WSHMSTR_CLKIN) begin
        if (WSHMSTR_RSTIN) begin
            r_state     <= S_IDLE;
            r_cyc       <= 1'b0;
            r_lockout   <= 1'b0;
            r_done      <= 1'b0;
            r_errcode   <= c_err_ok;
            r_rdata     <= '0;
            r_tgdin     <= '0;
            r_retry_cnt <= '0;
            r_wren      <= 1'b0;
            r_lock      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_tga       <= '0;
            r_tgc       <= '0;
            r_tgd       <= '0;
        end else begin
            r_state   <= w_next;
            r_cyc     <= (w_next == S_CYCLE);
            r_lockout <= (w_next == S_CYCLE) && w_lock_nxt;
            r_done    <= w_done;
            if (w_done) r_errcode <= w_errcode;
            if (w_capture) begin
                r_rdata <= WSHMSTR_DATAIN;
                r_tgdin <= WSHMSTR_TGDIN;
            end
            if (w_accept) begin
                r_retry_cnt <= '0;
                r_wren      <= CPU_WREN;
                r_lock      <= CPU_LOCK;
                r_addr      <= CPU_ADDR;
                r_wdata     <= CPU_WDATA;
                r_sel       <= CPU_SEL;
                r_tga       <= CPU_TGA;
                r_tgc       <= CPU_TGC;
                r_tgd       <= CPU_TGD;
            end else if (w_retry_inc) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end
        end
    end

    assign CPU_BUSY        = (r_state != S_IDLE);
    assign CPU_DONE        = r_done;
    assign CPU_ERRCODE     = r_errcode;
    assign CPU_RDATA       = r_rdata;
    assign CPU_TGDIN       = r_tgdin;
    assign WSHMSTR_CYC     = r_cyc;
    assign WSHMSTR_STROBE  = r_cyc;
    assign WSHMSTR_WREN    = r_wren;
    assign WSHMSTR_LOCKOUT = r_lockout;
    assign WSHMSTR_ADDROUT = r_addr;
    assign WSHMSTR_DATAOUT = r_wdata;
    assign WSHMSTR_SEL     = r_sel;
    assign WSHMSTR_TGA     = r_tga;
    assign WSHMSTR_TGC     = r_tgc;
    assign WSHMSTR_TGDOUT  = r_tgd;

endmodule
`default_nettype wire
